// File: rtl/multiword_add_sequencer.sv
// Streams multi-word add/sub through one shared 32-bit adder, LSW first, with carry chaining and a packet length cap.
// Optional signed-overflow output enabled by defining MULTIWORD_ADD_SIGNED_OVF_EN.
module multiword_add_sequencer #(
  parameter  int WORDS_MAX = 4,
  localparam int IDX_W     = (WORDS_MAX > 2) ? $clog2(WORDS_MAX) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_last,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_carry,
  output logic             out_err
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  typedef enum logic {FIRST, MID} state_t;

  state_t           state;
  logic             carryQ;
  logic             subQ;
  logic [IDX_W-1:0] cnt;

  logic             accept;
  logic             subSel;
  logic [31:0]      addB;
  logic             addCin;
  logic [31:0]      sum;
  logic             cout;
  logic             lastBeat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Operation and carry-in come from the beat itself on word 0, from the held packet state afterwards.
  assign subSel   = (state == FIRST) ? in_sub : subQ;
  assign addB     = subSel ? ~in_b : in_b;
  assign addCin   = (state == FIRST) ? (in_sub | in_cin) : carryQ;
  assign {cout, sum} = {1'b0, in_a} + {1'b0, addB} + {32'd0, addCin};
  assign lastBeat = in_last || (cnt == IDX_W'(WORDS_MAX - 1));

`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
  logic c31;
  assign c31 = in_a[31] ^ addB[31] ^ sum[31];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FIRST;
      carryQ    <= 1'b0;
      subQ      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_sum   <= sum;
        out_carry <= cout;
        out_idx   <= cnt;
        out_last  <= lastBeat;
        out_err   <= lastBeat && !in_last;
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
        out_ovf   <= lastBeat ? (c31 ^ cout) : 1'b0;
`endif
        if (state == FIRST) begin
          subQ <= in_sub;
        end
        // A forced last closes the packet just like in_last, so the next beat starts clean.
        if (lastBeat) begin
          state  <= FIRST;
          cnt    <= '0;
          carryQ <= 1'b0;
        end else begin
          state  <= MID;
          cnt    <= cnt + 1'b1;
          carryQ <= cout;
        end
      end
    end
  end

endmodule
